// File: rtl/operand_forward_ctrl.sv
// Operand-forwarding and load-use hazard controller for a 5-stage in-order pipeline.
// Optional feature macro: FORWARD_WB_HOLD_EN adds the WB shadow stage and selector 3.
module operand_forward_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       idValid,
    input  logic [4:0] idRs1,
    input  logic [4:0] idRs2,
    input  logic [4:0] idRd,
    input  logic       idRegWrite,
    input  logic       idMemRead,
    input  logic       flush,
    output logic [1:0] forwardA,
    output logic [1:0] forwardB,
    output logic       stall
);

    localparam logic [1:0] SEL_RF     = 2'd0;
    localparam logic [1:0] SEL_EXMEM  = 2'd1;
    localparam logic [1:0] SEL_MEMWB  = 2'd2;
`ifdef FORWARD_WB_HOLD_EN
    localparam logic [1:0] SEL_WBHOLD = 2'd3;
`endif

    logic       r_ex_valid;
    logic [4:0] r_ex_rd;
    logic       r_ex_regwrite;
    logic       r_ex_memread;

    logic       r_mem_valid;
    logic [4:0] r_mem_rd;
    logic       r_mem_regwrite;

`ifdef FORWARD_WB_HOLD_EN
    logic       r_wb_valid;
    logic [4:0] r_wb_rd;
    logic       r_wb_regwrite;
    logic       w_wb_wr;
`endif

    logic       w_ex_wr;
    logic       w_mem_wr;
    logic       w_hazard;
    logic       w_load_ex;
    logic [1:0] w_sel_a;
    logic [1:0] w_sel_b;

    // Youngest producer wins; x0 is never a source of forwarded data.
`ifdef FORWARD_WB_HOLD_EN
    function automatic logic [1:0] f_fwd_sel(
        input logic [4:0] rs,
        input logic       ex_wr,
        input logic [4:0] ex_rd,
        input logic       mem_wr,
        input logic [4:0] mem_rd,
        input logic       wb_wr,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs == 5'd0)
            sel = SEL_RF;
        else if (ex_wr && (ex_rd == rs))
            sel = SEL_EXMEM;
        else if (mem_wr && (mem_rd == rs))
            sel = SEL_MEMWB;
        else if (wb_wr && (wb_rd == rs))
            sel = SEL_WBHOLD;
        return sel;
    endfunction
`else
    function automatic logic [1:0] f_fwd_sel(
        input logic [4:0] rs,
        input logic       ex_wr,
        input logic [4:0] ex_rd,
        input logic       mem_wr,
        input logic [4:0] mem_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (rs == 5'd0)
            sel = SEL_RF;
        else if (ex_wr && (ex_rd == rs))
            sel = SEL_EXMEM;
        else if (mem_wr && (mem_rd == rs))
            sel = SEL_MEMWB;
        return sel;
    endfunction
`endif

    assign w_ex_wr  = r_ex_valid  & r_ex_regwrite  & (r_ex_rd  != 5'd0);
    assign w_mem_wr = r_mem_valid & r_mem_regwrite & (r_mem_rd != 5'd0);
`ifdef FORWARD_WB_HOLD_EN
    assign w_wb_wr  = r_wb_valid  & r_wb_regwrite  & (r_wb_rd  != 5'd0);
    assign w_sel_a  = f_fwd_sel(idRs1, w_ex_wr, r_ex_rd, w_mem_wr, r_mem_rd, w_wb_wr, r_wb_rd);
    assign w_sel_b  = f_fwd_sel(idRs2, w_ex_wr, r_ex_rd, w_mem_wr, r_mem_rd, w_wb_wr, r_wb_rd);
`else
    assign w_sel_a  = f_fwd_sel(idRs1, w_ex_wr, r_ex_rd, w_mem_wr, r_mem_rd);
    assign w_sel_b  = f_fwd_sel(idRs2, w_ex_wr, r_ex_rd, w_mem_wr, r_mem_rd);
`endif

    // A load in EX cannot supply its data until MEM, so its consumer waits one cycle.
    assign w_hazard = idValid & r_ex_valid & r_ex_memread & (r_ex_rd != 5'd0)
                    & ((r_ex_rd == idRs1) | (r_ex_rd == idRs2)) & ~flush;
    assign stall     = w_hazard & ~reset;
    assign w_load_ex = idValid & ~w_hazard & ~flush;

    // ID -> EX boundary plus shadow advance EX -> MEM -> WB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= 5'd0;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= 5'd0;
            r_mem_regwrite <= 1'b0;
`ifdef FORWARD_WB_HOLD_EN
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_regwrite  <= 1'b0;
`endif
            forwardA       <= SEL_RF;
            forwardB       <= SEL_RF;
        end else begin
            r_ex_valid     <= w_load_ex;
            r_ex_rd        <= w_load_ex ? idRd : 5'd0;
            r_ex_regwrite  <= w_load_ex & idRegWrite;
            r_ex_memread   <= w_load_ex & idMemRead;
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
`ifdef FORWARD_WB_HOLD_EN
            r_wb_valid     <= r_mem_valid;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
`endif
            forwardA       <= w_load_ex ? w_sel_a : SEL_RF;
            forwardB       <= w_load_ex ? w_sel_b : SEL_RF;
        end
    end

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Directed bench for operand_forward_ctrl; expectations follow FORWARD_WB_HOLD_EN when defined.
module tb_operand_forward_ctrl;

    logic       clk;
    logic       reset;
    logic       idValid;
    logic [4:0] idRs1;
    logic [4:0] idRs2;
    logic [4:0] idRd;
    logic       idRegWrite;
    logic       idMemRead;
    logic       flush;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic       stall;

    int total;
    int bad;

    operand_forward_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .idValid    (idValid),
        .idRs1      (idRs1),
        .idRs2      (idRs2),
        .idRd       (idRd),
        .idRegWrite (idRegWrite),
        .idMemRead  (idMemRead),
        .flush      (flush),
        .forwardA   (forwardA),
        .forwardB   (forwardB),
        .stall      (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        idValid    = v;
        idRs1      = rs1;
        idRs2      = rs2;
        idRd       = rd;
        idRegWrite = rw;
        idMemRead  = mr;
        flush      = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL rst_fwdA: got %0d want 0", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL rst_fwdB: got %0d want 0", forwardB); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", stall); end
        reset = 1'b0;
        drive(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_first_stall: got %0b want 0", stall); end
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL rst_first_fwdA: got %0d want 0", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL rst_first_fwdB: got %0d want 0", forwardB); end
        drain();
    endtask

    task automatic test_ex_forward;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (forwardA !== 2'd1) begin bad++; $display("FAIL ex_fwdA: got %0d want 1", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL ex_fwdB: got %0d want 0", forwardB); end
        drain();
    endtask

    task automatic test_mem_wb;
        logic [1:0] exp_wb;
`ifdef FORWARD_WB_HOLD_EN
        exp_wb = 2'd3;
`else
        exp_wb = 2'd0;
`endif
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd7, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (forwardB !== 2'd2) begin bad++; $display("FAIL mem_fwdB: got %0d want 2", forwardB); end
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL mem_fwdA: got %0d want 0", forwardA); end
        drain();
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd3, 5'd7, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (forwardB !== exp_wb) begin bad++; $display("FAIL wb_fwdB: got %0d want %0d", forwardB, exp_wb); end
        drain();
    endtask

    task automatic test_load_use;
        drive(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall_on: got %0b want 1", stall); end
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL lu_bubble_fwdA: got %0d want 0", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL lu_bubble_fwdB: got %0d want 0", forwardB); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_off: got %0b want 0", stall); end
        tick();
        total++; if (forwardA !== 2'd2) begin bad++; $display("FAIL lu_fwdA: got %0d want 2", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL lu_fwdB: got %0d want 0", forwardB); end
        drive(1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_next_stall: got %0b want 0", stall); end
        tick();
        total++; if (forwardA !== 2'd1) begin bad++; $display("FAIL lu_next_fwdA: got %0d want 1", forwardA); end
        drain();
    endtask

    task automatic test_flush;
        drive(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd9, 5'd11, 1'b1, 1'b0, 1'b1);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall: got %0b want 0", stall); end
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL fl_fwdA: got %0d want 0", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL fl_fwdB: got %0d want 0", forwardB); end
        drive(1'b1, 5'd11, 5'd9, 5'd12, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_after_stall: got %0b want 0", stall); end
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL fl_killed_fwdA: got %0d want 0", forwardA); end
        total++; if (forwardB !== 2'd2) begin bad++; $display("FAIL fl_load_fwdB: got %0d want 2", forwardB); end
        drain();
    endtask

    task automatic test_x0_and_priority;
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall: got %0b want 0", stall); end
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL x0_fwdA: got %0d want 0", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL x0_fwdB: got %0d want 0", forwardB); end
        drain();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (forwardA !== 2'd1) begin bad++; $display("FAIL young_fwdA: got %0d want 1", forwardA); end
        total++; if (forwardB !== 2'd1) begin bad++; $display("FAIL young_fwdB: got %0d want 1", forwardB); end
        drain();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (forwardA !== 2'd2) begin bad++; $display("FAIL split_fwdA: got %0d want 2", forwardA); end
        total++; if (forwardB !== 2'd1) begin bad++; $display("FAIL split_fwdB: got %0d want 1", forwardB); end
        drain();
        drive(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL nowrite_fwdA: got %0d want 0", forwardA); end
        drain();
    endtask

    task automatic test_reset_mid_stall;
        drive(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd9, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rms_pre_stall: got %0b want 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rms_stall: got %0b want 0", stall); end
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL rms_fwdA: got %0d want 0", forwardA); end
        total++; if (forwardB !== 2'd0) begin bad++; $display("FAIL rms_fwdB: got %0d want 0", forwardB); end
        tick();
        total++; if (forwardA !== 2'd0) begin bad++; $display("FAIL rms_mem_clear: got %0d want 0", forwardA); end
        drain();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_ex_forward();
        test_mem_wb();
        test_load_use();
        test_flush();
        test_x0_and_priority();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
